// File: rtl/mem_responder.sv
// Single-outstanding memory responder: 64-bit word RAM, WAIT_CYCLES wait states, one-cycle response pulse.
// Define MEM_RESP_HOLD_EN to keep rdata_mem at the last read response between responses.
module mem_responder #(
    parameter int DEPTH       = 1024,
    parameter int ADDR_W      = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [63:0] req_addr,
    input  logic        req_we,
    input  logic [63:0] req_wdata,
    input  logic [7:0]  req_wmask,
    output logic        mem_stall,
    output logic        resp_valid,
    output logic [63:0] rdata_mem,
    output logic        resp_err
);
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    state_t            state_reg, state_next;
    logic [3:0]        cnt_reg, cnt_next;
    logic [ADDR_W-1:0] idx_reg;
    logic              we_reg;
    logic              err_reg;
    logic [63:0]       wdata_reg;
    logic [7:0]        wmask_reg;

    logic [63:0]       ram [DEPTH];
    logic [63:0]       ram_q_reg;
    logic [63:0]       fwd_data_reg;
    logic              fwd_reg;
    logic [63:0]       word;
    logic [63:0]       merged;

    logic              accept;
    logic              commit;
    logic [ADDR_W-1:0] req_idx;
    logic [ADDR_W-1:0] rd_idx;
    logic              req_oob;
    logic              addr_lsb_unused;

    assign req_idx         = req_addr[ADDR_W+2:3];
    assign req_oob         = |req_addr[63:ADDR_W+3];
    assign addr_lsb_unused = ^req_addr[2:0];
    assign accept          = req_valid && (state_reg != WAIT);
    assign commit          = (state_reg == RESP) && we_reg && !err_reg && !rst;

    // The word for the upcoming RESP is read on the edge entering RESP; when that edge also
    // commits a write to the same word, the merged value is forwarded instead of the stale RAM output.
    assign rd_idx = (state_reg == WAIT) ? idx_reg : req_idx;
    assign word   = fwd_reg ? fwd_data_reg : ram_q_reg;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_merge
            assign merged[gi*8 +: 8] = wmask_reg[gi] ? wdata_reg[gi*8 +: 8] : word[gi*8 +: 8];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 4'd0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < 8; b++) begin
                if (wmask_reg[b]) begin
                    ram[idx_reg][b*8 +: 8] <= wdata_reg[b*8 +: 8];
                end
            end
        end
        ram_q_reg <= ram[rd_idx];
    end

    always_ff @(posedge clk) begin
        fwd_reg      <= commit && (rd_idx == idx_reg);
        fwd_data_reg <= merged;
        if (accept) begin
            idx_reg   <= req_idx;
            we_reg    <= req_we;
            err_reg   <= req_oob;
            wdata_reg <= req_wdata;
            wmask_reg <= req_wmask;
        end
    end

`ifdef MEM_RESP_HOLD_EN
    logic [63:0] hold_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_reg <= 64'd0;
        end else if ((state_reg == RESP) && !we_reg) begin
            hold_reg <= err_reg ? 64'd0 : word;
        end
    end
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE, RESP: begin
                if (req_valid) begin
                    state_next = (WAIT_CYCLES > 0) ? WAIT : RESP;
                    cnt_next   = WAIT_LOAD;
                end else begin
                    state_next = IDLE;
                end
            end
            WAIT: begin
                cnt_next = cnt_reg - 4'd1;
                if (cnt_reg == 4'd1) begin
                    state_next = RESP;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_stall  = (state_reg == WAIT) || req_valid;
        resp_valid = (state_reg == RESP);
        resp_err   = (state_reg == RESP) && err_reg;
`ifdef MEM_RESP_HOLD_EN
        rdata_mem = hold_reg;
        if ((state_reg == RESP) && !we_reg) begin
            rdata_mem = err_reg ? 64'd0 : word;
        end
`else
        rdata_mem = 64'd0;
        if ((state_reg == RESP) && !we_reg && !err_reg) begin
            rdata_mem = word;
        end
`endif
    end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (WAIT_CYCLES=2 and 0), directed table, corner sequences,
// and randomized traffic checked against a word-array model of the memory.
module tb_mem_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid  [2];
    logic [63:0] req_addr   [2];
    logic        req_we     [2];
    logic [63:0] req_wdata  [2];
    logic [7:0]  req_wmask  [2];
    logic        mem_stall  [2];
    logic        resp_valid [2];
    logic [63:0] rdata_mem  [2];
    logic        resp_err   [2];

    int compared   = 0;
    int mismatched = 0;

    logic [63:0] mdl      [2][1024];
    logic [63:0] hold_exp [2];

    typedef struct {
        int          d;
        logic [63:0] addr;
        logic        we;
        logic [63:0] wdata;
        logic [7:0]  wmask;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs [18];

    always #5 clk = ~clk;

    mem_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(2)) dut_a (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[0]), .req_addr(req_addr[0]), .req_we(req_we[0]),
        .req_wdata(req_wdata[0]), .req_wmask(req_wmask[0]),
        .mem_stall(mem_stall[0]), .resp_valid(resp_valid[0]),
        .rdata_mem(rdata_mem[0]), .resp_err(resp_err[0])
    );

    mem_responder #(.DEPTH(1024), .ADDR_W(10), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst),
        .req_valid(req_valid[1]), .req_addr(req_addr[1]), .req_we(req_we[1]),
        .req_wdata(req_wdata[1]), .req_wmask(req_wmask[1]),
        .mem_stall(mem_stall[1]), .resp_valid(resp_valid[1]),
        .rdata_mem(rdata_mem[1]), .resp_err(resp_err[1])
    );

    function automatic int wc(int d);
        return (d == 0) ? 2 : 0;
    endfunction

    function automatic logic [63:0] idle_rdata(int d);
`ifdef MEM_RESP_HOLD_EN
        return hold_exp[d];
`else
        return 64'd0;
`endif
    endfunction

    function automatic logic [63:0] merge(logic [63:0] old, logic [63:0] wd, logic [7:0] wm);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) begin
            if (wm[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        end
        return r;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic issue(int d, logic [63:0] a, logic we, logic [63:0] wd, logic [7:0] wm);
        req_valid[d] = 1'b1;
        req_addr[d]  = a;
        req_we[d]    = we;
        req_wdata[d] = wd;
        req_wmask[d] = wm;
    endtask

    // Starts in the acceptance cycle; returns inside the response cycle with req_valid still high.
    task automatic wait_resp(int d, output logic [63:0] rd, output logic err,
                             output int lat, output int stalls);
        lat    = 0;
        stalls = 0;
        #1;
        if (mem_stall[d]) stalls++;
        do begin
            @(negedge clk);
            #1;
            lat++;
            if (resp_valid[d]) break;
            if (mem_stall[d]) stalls++;
        end while (lat < 50);
        if (!resp_valid[d]) chk("resp_timeout", 64'(resp_valid[d]), 64'd1);
        rd  = rdata_mem[d];
        err = resp_err[d];
    endtask

    task automatic step(int d, logic [63:0] a, logic we, logic [63:0] wd, logic [7:0] wm,
                        logic [63:0] exp_rd, logic exp_err, string tag);
        logic [63:0] rd;
        logic        err;
        int          lat;
        int          st;
        logic [63:0] want;
        wait_resp(d, rd, err, lat, st);
        want = we ? idle_rdata(d) : exp_rd;
        chk({tag, "_latency"}, 64'(lat), 64'(wc(d) + 1));
        chk({tag, "_stall_cycles"}, 64'(st), 64'(wc(d) + 1));
        chk({tag, "_rdata"}, rd, want);
        chk({tag, "_err"}, 64'(err), 64'(exp_err));
        $display("txn dut%0d %s addr=%h we=%0b wdata=%h wmask=%h -> rdata=%h err=%0b lat=%0d",
                 d, tag, a, we, wd, wm, rd, err, lat);
        if (!we) hold_exp[d] = exp_rd;
        else if (!exp_err) mdl[d][a[12:3]] = merge(mdl[d][a[12:3]], wd, wm);
    endtask

    task automatic idle_cycle(int d);
        req_valid[d] = 1'b0;
        #1;
        chk("stall_in_resp_no_req", 64'(mem_stall[d]), 64'd0);
        @(negedge clk);
        #1;
        chk("idle_resp_valid", 64'(resp_valid[d]), 64'd0);
        chk("idle_stall", 64'(mem_stall[d]), 64'd0);
        chk("idle_rdata", rdata_mem[d], idle_rdata(d));
    endtask

    task automatic gen(output logic [63:0] a, output logic we, output logic [63:0] wd,
                       output logic [7:0] wm);
        a = 64'((32 + $urandom_range(0, 7)) * 8) | 64'($urandom_range(0, 7));
        if ($urandom_range(0, 5) == 0) a = a | (64'd1 << $urandom_range(13, 63));
        we = 1'($urandom_range(0, 1));
        wd = {$urandom, $urandom};
        wm = 8'($urandom_range(0, 255));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ca, exp_rd;
        logic        cwe, in_range;
        logic [63:0] cwd;
        logic [7:0]  cwm;

        vecs[0]  = '{0, 64'h10, 1'b1, 64'h1122334455667788, 8'hFF, 64'h0, 1'b0};
        vecs[1]  = '{0, 64'h10, 1'b0, 64'h0, 8'h00, 64'h1122334455667788, 1'b0};
        vecs[2]  = '{0, 64'h10, 1'b1, 64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h0, 1'b0};
        vecs[3]  = '{0, 64'h10, 1'b0, 64'h0, 8'h00, 64'h11223344AAAAAAAA, 1'b0};
        vecs[4]  = '{0, 64'h18, 1'b1, 64'hCAFEF00DDEADBEEF, 8'hFF, 64'h0, 1'b0};
        vecs[5]  = '{0, 64'h00, 1'b1, 64'h0123456789ABCDEF, 8'hFF, 64'h0, 1'b0};
        vecs[6]  = '{0, 64'h10000, 1'b0, 64'h0, 8'h00, 64'h0, 1'b1};
        vecs[7]  = '{0, 64'h10000, 1'b1, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 1'b1};
        vecs[8]  = '{0, 64'h00, 1'b0, 64'h0, 8'h00, 64'h0123456789ABCDEF, 1'b0};
        vecs[9]  = '{0, 64'h1D, 1'b0, 64'h0, 8'h00, 64'hCAFEF00DDEADBEEF, 1'b0};
        vecs[10] = '{0, 64'h18, 1'b1, 64'h0, 8'h00, 64'h0, 1'b0};
        vecs[11] = '{0, 64'h18, 1'b0, 64'h0, 8'h00, 64'hCAFEF00DDEADBEEF, 1'b0};
        vecs[12] = '{0, 64'h20, 1'b1, 64'h0F1E2D3C4B5A6978, 8'hFF, 64'h0, 1'b0};
        vecs[13] = '{0, 64'hFFFFFFFFFFFFFFF8, 1'b0, 64'h0, 8'h00, 64'h0, 1'b1};
        vecs[14] = '{1, 64'h40, 1'b1, 64'h0011223344556677, 8'hFF, 64'h0, 1'b0};
        vecs[15] = '{1, 64'h40, 1'b0, 64'h0, 8'h00, 64'h0011223344556677, 1'b0};
        vecs[16] = '{1, 64'h10000, 1'b0, 64'h0, 8'h00, 64'h0, 1'b1};
        vecs[17] = '{1, 64'h48, 1'b1, 64'h8877665544332211, 8'hFF, 64'h0, 1'b0};

        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            req_valid[d] = 1'b0;
            req_addr[d]  = 64'd0;
            req_we[d]    = 1'b0;
            req_wdata[d] = 64'd0;
            req_wmask[d] = 8'd0;
            hold_exp[d]  = 64'd0;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("reset_stall", 64'(mem_stall[d]), 64'd0);
            chk("reset_resp_valid", 64'(resp_valid[d]), 64'd0);
            chk("reset_rdata", rdata_mem[d], 64'd0);
            chk("reset_err", 64'(resp_err[d]), 64'd0);
        end
        rst = 1'b0;

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            issue(vecs[i].d, vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].wmask);
            step(vecs[i].d, vecs[i].addr, vecs[i].we, vecs[i].wdata, vecs[i].wmask,
                 vecs[i].exp_rdata, vecs[i].exp_err, $sformatf("vec%0d", i));
            idle_cycle(vecs[i].d);
        end

        // Back-to-back reads: the second request is accepted in the first one's response cycle.
        @(negedge clk);
        issue(0, 64'h10, 1'b0, 64'h0, 8'h00);
        step(0, 64'h10, 1'b0, 64'h0, 8'h00, 64'h11223344AAAAAAAA, 1'b0, "b2b_first");
        issue(0, 64'h18, 1'b0, 64'h0, 8'h00);
        step(0, 64'h18, 1'b0, 64'h0, 8'h00, 64'hCAFEF00DDEADBEEF, 1'b0, "b2b_second");
        idle_cycle(0);

        // Zero wait states: read-after-write and write-after-write to the same word, no bubbles.
        @(negedge clk);
        issue(1, 64'h40, 1'b1, 64'hFFEEDDCCBBAA9988, 8'hF0);
        step(1, 64'h40, 1'b1, 64'hFFEEDDCCBBAA9988, 8'hF0, 64'h0, 1'b0, "raw_write");
        issue(1, 64'h40, 1'b0, 64'h0, 8'h00);
        step(1, 64'h40, 1'b0, 64'h0, 8'h00, 64'hFFEEDDCC44556677, 1'b0, "raw_read");
        issue(1, 64'h48, 1'b1, 64'h00000000000000AB, 8'h01);
        step(1, 64'h48, 1'b1, 64'h00000000000000AB, 8'h01, 64'h0, 1'b0, "waw_write");
        issue(1, 64'h48, 1'b0, 64'h0, 8'h00);
        step(1, 64'h48, 1'b0, 64'h0, 8'h00, 64'h88776655443322AB, 1'b0, "waw_read");
        idle_cycle(1);

        // Reset during the second wait state of a write: no response, no RAM update.
        @(negedge clk);
        issue(0, 64'h20, 1'b1, 64'hDEADDEADDEADDEAD, 8'hFF);
        @(negedge clk);
        #1;
        chk("abort_stall_wait", 64'(mem_stall[0]), 64'd1);
        @(negedge clk);
        rst          = 1'b1;
        req_valid[0] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        hold_exp[0] = 64'd0;
        hold_exp[1] = 64'd0;
        #1;
        chk("abort_rdata_cleared", rdata_mem[0], 64'd0);
        chk("abort_rdata_cleared_b", rdata_mem[1], 64'd0);
        for (int k = 0; k < 4; k++) begin
            chk("abort_no_resp", 64'(resp_valid[0]), 64'd0);
            chk("abort_stall", 64'(mem_stall[0]), 64'd0);
            @(negedge clk);
            #1;
        end
        @(negedge clk);
        issue(0, 64'h20, 1'b0, 64'h0, 8'h00);
        step(0, 64'h20, 1'b0, 64'h0, 8'h00, 64'h0F1E2D3C4B5A6978, 1'b0, "abort_readback");
        idle_cycle(0);

        // Randomized traffic over eight words per instance, with random chaining and aliasing.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) begin
                @(negedge clk);
                ca  = 64'((32 + i) * 8);
                cwd = {$urandom, $urandom};
                issue(d, ca, 1'b1, cwd, 8'hFF);
                step(d, ca, 1'b1, cwd, 8'hFF, 64'h0, 1'b0, "rnd_init");
                idle_cycle(d);
            end
            @(negedge clk);
            gen(ca, cwe, cwd, cwm);
            issue(d, ca, cwe, cwd, cwm);
            for (int n = 0; n < 60; n++) begin
                in_range = (ca[63:13] == 51'd0);
                exp_rd   = in_range ? mdl[d][ca[12:3]] : 64'd0;
                step(d, ca, cwe, cwd, cwm, exp_rd, !in_range, "rnd");
                if (n == 59 || $urandom_range(0, 1) == 0) begin
                    idle_cycle(d);
                    if (n != 59) begin
                        gen(ca, cwe, cwd, cwm);
                        issue(d, ca, cwe, cwd, cwm);
                    end
                end else begin
                    gen(ca, cwe, cwd, cwm);
                    issue(d, ca, cwe, cwd, cwm);
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
